// File: rtl/elev_pkg.sv
// Shared definitions for the elevator timing slice.
//   state_t       : arbiter FSM states (IDLE, RUN, DONE)
//   CLK_HZ_DEFAULT: board clock frequency
//   TICK_HZ_MS    : millisecond tick rate
//   REQ_*         : requester index assignments on the req/grant/done vectors
package elev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int TICK_HZ_MS     = 1000;

  localparam int unsigned REQ_DOOR   = 0;
  localparam int unsigned REQ_TRAVEL = 1;
  localparam int unsigned REQ_IDLE   = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set search.
//   i_req   : N-bit request vector
//   i_ptr   : index where the search starts (must be < N)
//   o_idx   : first set index at or above i_ptr, wrapping to 0
//   o_valid : at least one request is set
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = IW'((32'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_j]) begin
        o_valid = 1'b1;
        o_idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/elev_timer_arb.sv
// Shared millisecond interval timer arbitrated round-robin between N requesters.
//   clk_in    : board clock
//   rst       : synchronous reset, active-high
//   req       : level request per requester, held until done or cancel
//   dur       : packed durations in ticks, slice i = dur[i*DW +: DW]
//   grant     : one-hot current timer owner
//   done      : one-cycle completion pulse to the owner
//   busy      : timer owned (state != IDLE)
//   remaining : ticks left for the current owner, 0 when idle
module elev_timer_arb
  import elev_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int TICK_HZ = TICK_HZ_MS,
  parameter int N       = 3,
  parameter int DW      = 16
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] dur,
  output logic [N-1:0]    grant,
  output logic [N-1:0]    done,
  output logic            busy,
  output logic [DW-1:0]   remaining
);

  localparam int PRE = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(PRE);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_owner;

  logic [IW-1:0] w_pick;
  logic          w_valid;
  logic [DW-1:0] w_dur;
  logic [IW-1:0] w_next;
  logic          w_tick;
  logic          w_cancel;
  logic          w_finish;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick),
    .o_valid (w_valid)
  );

  assign w_dur  = dur[w_pick*DW +: DW];
  assign w_next = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;
  assign w_tick = (r_pre == PW'(PRE - 1));

  // A zero-duration grant sits in RUN for its single grant cycle with
  // remaining==0 and finishes unconditionally; otherwise a dropped request
  // cancels before the final tick can complete.
  assign w_cancel = !req[r_owner] && (remaining != '0);
  assign w_finish = (remaining == '0) ||
                    (req[r_owner] && w_tick && remaining == DW'(1));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pre     <= '0;
      r_ptr     <= '0;
      r_owner   <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= '0;
          if (w_valid) begin
            r_owner   <= w_pick;
            grant     <= N'(1) << w_pick;
            remaining <= w_dur;
            r_pre     <= '0;
            busy      <= 1'b1;
            r_state   <= ST_RUN;
          end else begin
            grant     <= '0;
            busy      <= 1'b0;
            remaining <= '0;
          end
        end
        ST_RUN: begin
          if (w_finish) begin
            done      <= grant;
            grant     <= '0;
            remaining <= '0;
            r_pre     <= '0;
            r_ptr     <= w_next;
            r_state   <= ST_DONE;
          end else if (w_cancel) begin
            grant     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            r_pre     <= '0;
            r_ptr     <= w_next;
            r_state   <= ST_IDLE;
          end else if (w_tick) begin
            r_pre     <= '0;
            remaining <= remaining - 1'b1;
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end
        ST_DONE: begin
          done    <= '0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elev_timer_arb.sv
// Self-checking bench for elev_timer_arb (CLK_HZ=10, TICK_HZ=1 -> PRE=10, N=3).
module tb_elev_timer_arb;

  localparam int PRE = 10;
  localparam int NR  = 3;
  localparam int DW  = 16;

  logic              clk_in = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  dur;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic              busy;
  logic [DW-1:0]     remaining;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: transaction view (idle / owned for d*PRE cycles / done)
  int            m_phase;
  int            m_ptr;
  int            m_owner;
  int            m_d;
  int            m_k;
  logic [NR-1:0] e_grant;
  logic [NR-1:0] e_done;
  logic          e_busy;
  logic [DW-1:0] e_rem;

  elev_timer_arb #(.CLK_HZ(10), .TICK_HZ(1), .N(NR), .DW(DW)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .req       (req),
    .dur       (dur),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .remaining (remaining)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [NR*DW-1:0] mkdur(input int d0, input int d1, input int d2);
    return {DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  function automatic int first_from(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_zero();
    e_grant = '0; e_done = '0; e_busy = 1'b0; e_rem = '0;
  endtask

  task automatic model_update();
    int g;
    if (rst) begin
      model_zero();
      m_phase = 0;
      m_ptr   = 0;
      return;
    end
    case (m_phase)
      0: begin
        g = first_from(req, m_ptr);
        model_zero();
        if (g >= 0) begin
          m_owner = g;
          m_d     = int'(dur[g*DW +: DW]);
          m_k     = 1;
          e_grant = NR'(1 << g);
          e_rem   = DW'(m_d);
          e_busy  = 1'b1;
          m_phase = 1;
        end
      end
      1: begin
        if (m_d == 0 || (req[m_owner] && m_k == m_d * PRE)) begin
          model_zero();
          e_busy  = 1'b1;
          e_done  = NR'(1 << m_owner);
          m_ptr   = (m_owner + 1) % NR;
          m_phase = 2;
        end else if (!req[m_owner]) begin
          model_zero();
          m_ptr   = (m_owner + 1) % NR;
          m_phase = 0;
        end else begin
          e_rem = DW'(m_d - m_k / PRE);
          m_k++;
        end
      end
      default: begin
        model_zero();
        m_phase = 0;
      end
    endcase
  endtask

  task automatic step(input logic r, input logic [NR-1:0] q, input logic [NR*DW-1:0] d);
    @(negedge clk_in);
    rst = r; req = q; dur = d;
    @(posedge clk_in);
    model_update();
    #1;
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("remaining", 32'(remaining), 32'(e_rem));
  endtask

  initial begin
    int gcnt;
    int dcnt;
    int seen;
    logic [NR-1:0] prev;
    logic [NR-1:0] first_g;
    logic [NR-1:0] seq[$];
    logic [NR-1:0] exp_seq[4];
    logic [NR-1:0] rq;

    rst = 1'b0; req = '0; dur = '0;
    m_phase = 0; m_ptr = 0; m_owner = 0; m_d = 0; m_k = 0;
    model_zero();

    // 1: single request, dur=3
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    check_eq("reset_grant", 32'(grant), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    repeat (2) step(1'b0, '0, '0);
    gcnt = 0; dcnt = 0;
    for (int i = 0; i < 60 && dcnt == 0; i++) begin
      step(1'b0, 3'b001, mkdur(3, 0, 0));
      if (grant == 3'b001) gcnt++;
      if (done == 3'b001) dcnt++;
    end
    repeat (3) step(1'b0, '0, mkdur(3, 0, 0));
    check_eq("t1_grant_len", 32'(gcnt), 32'd30);
    check_eq("t1_done_cnt", 32'(dcnt), 32'd1);

    // 2: contention, all dur=1
    step(1'b1, '0, '0);
    prev = '0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 3'b111, mkdur(1, 1, 1));
      if (grant != '0 && prev == '0) seq.push_back(grant);
      prev = grant;
    end
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    check_eq("t2_grant_count", 32'(seq.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < seq.size(); i++) check_eq("t2_order", 32'(seq[i]), 32'(exp_seq[i]));

    // 3: cancel requester 1 at RUN cycle 20
    step(1'b1, '0, '0);
    seen = 0; dcnt = 0;
    for (int i = 0; i < 5 && seen == 0; i++) begin
      step(1'b0, 3'b010, mkdur(0, 5, 0));
      if (grant == 3'b010) seen = 1;
    end
    check_eq("t3_granted", 32'(seen), 32'd1);
    repeat (19) begin
      step(1'b0, 3'b010, mkdur(0, 5, 0));
      if (done != '0) dcnt++;
    end
    step(1'b0, 3'b000, mkdur(0, 5, 0));
    check_eq("t3_cancel_grant", 32'(grant), 32'd0);
    check_eq("t3_cancel_rem", 32'(remaining), 32'd0);
    first_g = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i < 2) ? 3'b000 : 3'b011, mkdur(2, 2, 2));
      if (done != '0) dcnt++;
      if (first_g == '0) first_g = grant;
    end
    check_eq("t3_no_done", 32'(dcnt), 32'd0);
    check_eq("t3_wrap_grant", 32'(first_g), 32'b001);

    // 4: zero duration
    step(1'b1, '0, '0);
    gcnt = 0; dcnt = 0;
    for (int i = 0; i < 10 && dcnt == 0; i++) begin
      step(1'b0, 3'b100, mkdur(0, 0, 0));
      if (grant == 3'b100) gcnt++;
      if (done == 3'b100) dcnt++;
    end
    step(1'b0, '0, '0);
    check_eq("t4_grant_len", 32'(gcnt), 32'd1);
    check_eq("t4_done_cnt", 32'(dcnt), 32'd1);

    // 5: reset at RUN cycle 7, pointer returns to 0
    step(1'b1, '0, '0);
    step(1'b0, 3'b001, mkdur(3, 3, 3));  // IDLE edge, pointer moved to 1 afterwards? no: only on done
    repeat (6) step(1'b0, 3'b001, mkdur(3, 3, 3));
    check_eq("t5_running", 32'(grant), 32'b001);
    step(1'b1, 3'b001, mkdur(3, 3, 3));
    check_eq("t5_rst_grant", 32'(grant), 32'd0);
    check_eq("t5_rst_rem", 32'(remaining), 32'd0);
    step(1'b0, 3'b110, mkdur(3, 3, 3));
    check_eq("t5_ptr_reset", 32'(grant), 32'b010);
    step(1'b0, 3'b000, mkdur(3, 3, 3));
    repeat (2) step(1'b0, 3'b000, mkdur(3, 3, 3));

    // 6: duration latched at grant
    step(1'b1, '0, '0);
    gcnt = 0; dcnt = 0;
    for (int i = 0; i < 60 && dcnt == 0; i++) begin
      step(1'b0, 3'b001, (gcnt == 0) ? mkdur(2, 0, 0) : mkdur(9, 0, 0));
      if (grant == 3'b001) gcnt++;
      if (done == 3'b001) dcnt++;
    end
    check_eq("t6_grant_len", 32'(gcnt), 32'd20);
    check_eq("t6_done_cnt", 32'(dcnt), 32'd1);

    // random traffic with sticky requests and churning durations
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NR; b++) if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
      step(($urandom_range(0, 299) == 0), rq,
           mkdur(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
